// File: rtl/cmos_raw2rgb.sv
// cmos_raw2rgb
// Bayer-to-RGB demosaic stage that sits directly behind the CMOS capture block.
// A 2x2 window is built from one line buffer (previous line) and a one-pixel
// delay (current line). Each valid window produces one full-precision RGB pixel.
// Row 0 and column 0 of every frame produce no output.
//
// Ports
//   iCLK    in   pixel clock
//   iRST_N  in   asynchronous active-low reset
//   iDATA   in   raw pixel, DATA_SIZE bits, used only while iDVAL=1
//   iDVAL   in   pixel valid, high across a line, low between lines
//   iSYNC   in   one-cycle frame-start pulse
//   oRed    out  red channel, DATA_SIZE bits
//   oGreen  out  green channel, DATA_SIZE bits
//   oBlue   out  blue channel, DATA_SIZE bits
//   oDVAL   out  RGB pixel valid
//   oSYNC   out  iSYNC aligned with the two-stage pixel pipeline
//   oOVF    out  sticky line-overflow flag, cleared by iSYNC

module cmos_raw2rgb #(
   parameter int DATA_SIZE  = 10,
   parameter int LINE_WIDTH = 640,
   parameter int BAYER      = 0
) (
   input  logic                 iCLK,
   input  logic                 iRST_N,
   input  logic [DATA_SIZE-1:0] iDATA,
   input  logic                 iDVAL,
   input  logic                 iSYNC,
   output logic [DATA_SIZE-1:0] oRed,
   output logic [DATA_SIZE-1:0] oGreen,
   output logic [DATA_SIZE-1:0] oBlue,
   output logic                 oDVAL,
   output logic                 oSYNC,
   output logic                 oOVF
);

   localparam int          ADDR_W     = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [15:0] LINE_LIMIT = 16'(LINE_WIDTH);
   localparam logic [1:0]  PHASE0     = 2'(BAYER);

   logic [DATA_SIZE-1:0] r_lineBuf [LINE_WIDTH];
   logic [DATA_SIZE-1:0] r_tl, r_tr, r_bl, r_br;
   logic [15:0]          r_col, r_row;
   logic                 r_dvalPrev;
   logic                 r_armed;
   logic                 r_validA, r_validB;
   logic [1:0]           r_phaseA;
   logic [DATA_SIZE-1:0] r_redB, r_greenB, r_blueB;
   logic                 r_syncA, r_syncB;

   logic [15:0]          w_col, w_row;
   logic                 w_inLine, w_pixValid;
   logic [ADDR_W-1:0]    w_addr;
   logic [DATA_SIZE:0]   w_sumMain, w_sumAnti;
   logic [DATA_SIZE-1:0] w_red, w_green, w_blue;

   // A frame-start pulse coincident with a pixel makes that pixel col 0 / row 0
   assign w_col      = iSYNC ? 16'd0 : r_col;
   assign w_row      = iSYNC ? 16'd0 : r_row;
   assign w_inLine   = (w_col < LINE_LIMIT);
   assign w_addr     = w_col[ADDR_W-1:0];
   assign w_pixValid = iDVAL && w_inLine && r_armed && (w_row != 16'd0) && (w_col != 16'd0);

   // Column/row position tracking; the column restarts once the line gap is seen
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_col      <= 16'd0;
         r_row      <= 16'd0;
         r_dvalPrev <= 1'b0;
         r_armed    <= 1'b0;
      end else if (iSYNC) begin
         r_col      <= iDVAL ? 16'd1 : 16'd0;
         r_row      <= 16'd0;
         r_dvalPrev <= iDVAL;
         r_armed    <= 1'b1;
      end else begin
         r_dvalPrev <= iDVAL;
         if (iDVAL) begin
            r_col <= r_col + 16'd1;
         end else begin
            r_col <= 16'd0;
            if (r_dvalPrev) begin
               r_row <= r_row + 16'd1;
            end
         end
      end
   end

   // Sticky overflow: any pixel beyond the buffer depth flags the frame
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oOVF <= 1'b0;
      end else if (iSYNC) begin
         oOVF <= 1'b0;
      end else if (iDVAL && !w_inLine) begin
         oOVF <= 1'b1;
      end
   end

   // Line buffer read-before-write plus the window shift registers.
   // TR is the buffer's old content (previous line), TL/BL are last pixel's TR/BR.
   // Overflowing pixels neither write the buffer nor shift the window.
   always_ff @(posedge iCLK) begin
      if (iDVAL && w_inLine) begin
         r_tr              <= r_lineBuf[w_addr];
         r_lineBuf[w_addr] <= iDATA;
         r_tl              <= r_tr;
         r_br              <= iDATA;
         r_bl              <= r_br;
      end
   end

   // Stage A qualifiers travel with the window; phase is TL's colour in RGGB terms
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_validA <= 1'b0;
         r_phaseA <= 2'd0;
      end else begin
         r_validA <= w_pixValid;
         r_phaseA <= PHASE0 ^ {~w_row[0], ~w_col[0]};
      end
   end

   // Channel selection; green averages the two diagonal green sites (truncating)
   always_comb begin
      w_sumMain = {1'b0, r_tl} + {1'b0, r_br};
      w_sumAnti = {1'b0, r_tr} + {1'b0, r_bl};
      w_red     = r_tl;
      w_green   = w_sumAnti[DATA_SIZE:1];
      w_blue    = r_br;
      case (r_phaseA)
         2'd0: begin
            w_red   = r_tl;
            w_green = w_sumAnti[DATA_SIZE:1];
            w_blue  = r_br;
         end
         2'd1: begin
            w_red   = r_tr;
            w_green = w_sumMain[DATA_SIZE:1];
            w_blue  = r_bl;
         end
         2'd2: begin
            w_red   = r_bl;
            w_green = w_sumMain[DATA_SIZE:1];
            w_blue  = r_tr;
         end
         2'd3: begin
            w_red   = r_br;
            w_green = w_sumAnti[DATA_SIZE:1];
            w_blue  = r_tl;
         end
      endcase
   end

   // Stage B and output stage; a frame start flushes everything in flight
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_validB <= 1'b0;
         r_redB   <= '0;
         r_greenB <= '0;
         r_blueB  <= '0;
         oDVAL    <= 1'b0;
         oRed     <= '0;
         oGreen   <= '0;
         oBlue    <= '0;
      end else begin
         r_validB <= r_validA && !iSYNC;
         r_redB   <= w_red;
         r_greenB <= w_green;
         r_blueB  <= w_blue;
         oDVAL    <= r_validB && !iSYNC;
         if (r_validB && !iSYNC) begin
            oRed   <= r_redB;
            oGreen <= r_greenB;
            oBlue  <= r_blueB;
         end
      end
   end

   // Frame sync follows the same number of register stages as the pixels
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_syncA <= 1'b0;
         r_syncB <= 1'b0;
         oSYNC   <= 1'b0;
      end else begin
         r_syncA <= iSYNC;
         r_syncB <= r_syncA;
         oSYNC   <= r_syncB;
      end
   end

endmodule
